// File: rtl/sdram_p2_arbiter.sv
// Round-robin arbiter sharing the SDRAM controller's port 2 between NUM clients.
// state   | meaning
// S_IDLE  | track p2_ack, pick next requester from ptr upward
// S_ISSUE | p2_cs high, waiting for p2_ack toggle or watchdog expiry
// S_GAP   | one cycle with p2_cs low after a completed access
// S_DRAIN | post-abort quiet period, late toggles absorbed silently
module sdram_p2_arbiter #(
  parameter int NUM     = 3,
  parameter int AW      = 22,
  parameter int TIMEOUT = 255,
  parameter int DRAIN   = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NUM-1:0]    c_req,
  input  logic [NUM-1:0]    c_we,
  input  logic [NUM*AW-1:0] c_addr,
  input  logic [NUM*16-1:0] c_din,
  input  logic [NUM*2-1:0]  c_ds,
  output logic [NUM-1:0]    c_ack,
  output logic [NUM-1:0]    c_err,
  output logic [15:0]       c_dout,
  output logic              p2_cs,
  output logic              p2_we,
  output logic [AW-1:0]     p2_addr,
  output logic [1:0]        p2_ds,
  output logic [15:0]       p2_din,
  input  logic [15:0]       p2_dout,
  input  logic              p2_ack
);

  localparam int PW = (NUM > 2) ? 2 : 1;
  localparam int DW = (DRAIN > 1) ? $clog2(DRAIN) : 1;
  localparam logic [DW-1:0] DRAIN_M1 = DW'(DRAIN - 1);
  localparam logic [7:0]    TO_M1    = 8'(TIMEOUT - 1);
  localparam logic [PW:0]   NUM_W    = (PW+1)'(NUM);
  localparam logic [PW-1:0] LAST     = PW'(NUM - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP, S_DRAIN} state_t;

  state_t          state, state_n;
  logic [PW-1:0]   ptr, ptr_n, g, g_n;
  logic [7:0]      timer, timer_n;
  logic [DW-1:0]   dcnt, dcnt_n;
  logic            ack_ref, ack_ref_n;
  logic [NUM-1:0]  c_ack_n, c_err_n;
  logic [15:0]     c_dout_n;
  logic            p2_cs_n, p2_we_n;
  logic [AW-1:0]   p2_addr_n;
  logic [1:0]      p2_ds_n;
  logic [15:0]     p2_din_n;

  logic            toggle;
  logic [NUM-1:0]  rot;
  logic            found;
  logic [PW-1:0]   off, win, ptr_next;
  logic [PW:0]     sum;
  logic [NUM-1:0]  g_oh;
  logic            sel_we;
  logic [AW-1:0]   sel_addr;
  logic [15:0]     sel_din;
  logic [1:0]      sel_ds;

  assign toggle = (p2_ack != ack_ref);

  // Rotate requests so bit 0 is the client at ptr; first set bit is the winner.
  assign rot = NUM'({c_req, c_req} >> ptr);

  always_comb begin
    found = 1'b0;
    off   = '0;
    for (int k = NUM - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        off   = PW'(k);
      end
    end
  end

  assign sum      = {1'b0, ptr} + {1'b0, off};
  assign win      = (sum >= NUM_W) ? PW'(sum - NUM_W) : PW'(sum);
  assign ptr_next = (g == LAST) ? '0 : g + 1'b1;

  always_comb begin
    sel_we   = 1'b0;
    sel_addr = '0;
    sel_din  = '0;
    sel_ds   = '0;
    for (int k = 0; k < NUM; k++) begin
      if (win == PW'(k)) begin
        sel_we   = c_we[k];
        sel_addr = c_addr[k*AW +: AW];
        sel_din  = c_din[k*16 +: 16];
        sel_ds   = c_ds[k*2 +: 2];
      end
    end
  end

  always_comb begin
    g_oh = '0;
    for (int k = 0; k < NUM; k++) g_oh[k] = (g == PW'(k));
  end

  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    g_n       = g;
    timer_n   = timer;
    dcnt_n    = dcnt;
    ack_ref_n = ack_ref;
    c_ack_n   = '0;
    c_err_n   = '0;
    c_dout_n  = c_dout;
    p2_cs_n   = p2_cs;
    p2_we_n   = p2_we;
    p2_addr_n = p2_addr;
    p2_ds_n   = p2_ds;
    p2_din_n  = p2_din;
    case (state)
      S_IDLE: begin
        ack_ref_n = p2_ack;
        if (found) begin
          g_n       = win;
          p2_we_n   = sel_we;
          p2_addr_n = sel_addr;
          p2_din_n  = sel_din;
          p2_ds_n   = sel_ds;
          p2_cs_n   = 1'b1;
          timer_n   = '0;
          state_n   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (timer != 8'hFF) timer_n = timer + 8'd1;
        // A completion arriving on the last watchdog cycle still counts.
        if (toggle) begin
          c_dout_n  = p2_dout;
          c_ack_n   = g_oh;
          p2_cs_n   = 1'b0;
          ack_ref_n = p2_ack;
          ptr_n     = ptr_next;
          state_n   = S_GAP;
        end else if (timer == TO_M1) begin
          c_err_n = g_oh;
          p2_cs_n = 1'b0;
          ptr_n   = ptr_next;
          timer_n = '0;
          dcnt_n  = DRAIN_M1;
          state_n = S_DRAIN;
        end
      end
      S_GAP: state_n = S_IDLE;
      S_DRAIN: begin
        ack_ref_n = p2_ack;
        if (dcnt == '0) state_n = S_IDLE;
        else dcnt_n = dcnt - 1'b1;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      ptr     <= '0;
      g       <= '0;
      timer   <= '0;
      dcnt    <= '0;
      ack_ref <= p2_ack;
      c_ack   <= '0;
      c_err   <= '0;
      c_dout  <= '0;
      p2_cs   <= 1'b0;
      p2_we   <= 1'b0;
      p2_addr <= '0;
      p2_ds   <= '0;
      p2_din  <= '0;
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      g       <= g_n;
      timer   <= timer_n;
      dcnt    <= dcnt_n;
      ack_ref <= ack_ref_n;
      c_ack   <= c_ack_n;
      c_err   <= c_err_n;
      c_dout  <= c_dout_n;
      p2_cs   <= p2_cs_n;
      p2_we   <= p2_we_n;
      p2_addr <= p2_addr_n;
      p2_ds   <= p2_ds_n;
      p2_din  <= p2_din_n;
    end
  end

endmodule
